// File: rtl/operand_loader.sv
// Operand loader: collects four signed bytes into A-D, then hands off to the control unit
// through a start/done handshake guarded by a watchdog. Define OPLOAD_OVF_PREDICT_EN to add overflow prediction.
module operand_loader (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_mode,
    input  logic       done,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [7:0] C,
    output logic [7:0] D,
    output logic       start,
    output logic       mode,
    output logic       busy,
    output logic       err,
    output logic       ovf_pred
);

    typedef enum logic [1:0] {LOAD, ISSUE, WAIT_DONE, WAIT_CLR} state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] wd_q, wd_d;
    logic [7:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic       mode_q, mode_d;
    logic       err_q, err_d;
    logic       start_q, start_d;
    logic       in_ready_q, in_ready_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        mode_d  = mode_q;
        err_d   = err_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    case (cnt_q)
                        2'd0: begin a_d = in_data; mode_d = in_mode; end
                        2'd1: b_d = in_data;
                        2'd2: c_d = in_data;
                        default: d_d = in_data;
                    endcase
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = 4'd0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                wd_d = wd_q + 4'd1;
                if (done) begin
                    state_d = WAIT_CLR;
                end else if (wd_q == 4'd15) begin
                    err_d   = 1'b1;
                    state_d = LOAD;
                end
            end
            default: begin
                if (!done) state_d = LOAD;
            end
        endcase
        // Handshake outputs are registered decodes of the next state, so no input reaches them combinationally.
        start_d    = (state_d == ISSUE) || (state_d == WAIT_DONE);
        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d != LOAD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= LOAD;
            cnt_q      <= 2'd0;
            wd_q       <= 4'd0;
            a_q        <= 8'd0;
            b_q        <= 8'd0;
            c_q        <= 8'd0;
            d_q        <= 8'd0;
            mode_q     <= 1'b0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
            mode_q     <= mode_d;
            err_q      <= err_d;
            start_q    <= start_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

`ifdef OPLOAD_OVF_PREDICT_EN
    logic [9:0] res_q, res_d;
    logic [9:0] ea, eb, ec, ed;

    // Use the next-state operands so the final byte accepted on the ISSUE entry edge is included.
    always_comb begin
        ea    = {{2{a_d[7]}}, a_d};
        eb    = {{2{b_d[7]}}, b_d};
        ec    = {{2{c_d[7]}}, c_d};
        ed    = {{2{d_d[7]}}, d_d};
        res_d = res_q;
        if (state_q == LOAD && state_d == ISSUE)
            res_d = mode_d ? (ea - eb + ec + ed) : (ea + eb + ec - ed);
    end

    always_ff @(posedge clock) begin
        if (reset) res_q <= 10'd0;
        else       res_q <= res_d;
    end

    assign ovf_pred = (res_q[9:7] != 3'b000) && (res_q[9:7] != 3'b111);
`else
    assign ovf_pred = 1'b0;
`endif

    assign in_ready = in_ready_q;
    assign start    = start_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign mode     = mode_q;
    assign A        = a_q;
    assign B        = b_q;
    assign C        = c_q;
    assign D        = d_q;

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clock  in  1  rising-edge clock shared with the control-unit FSM and add/sub datapath.
REQ-003 reset  in  1  synchronous, active-high; same net that clears the control unit and datapath.
REQ-004 in_valid  in  1  upstream byte valid.
REQ-005 in_ready  out  1  loader can accept a byte this cycle.
REQ-006 in_data  in  8  signed two's-complement operand byte.
REQ-007 in_mode  in  1  operation select; 0 = A+B+C-D, 1 = A-B+C+D; sampled with the first byte only.
REQ-008 done  in  1  completion flag from the control-unit FSM.
REQ-009 A, B, C, D  out  8 each  signed operands to the add/sub datapath.
REQ-010 start  out  1  start request to the control-unit FSM.
REQ-011 mode  out  1  registered mode to the control-unit FSM.
REQ-012 busy  out  1  high in every state except LOAD.
REQ-013 err  out  1  sticky timeout flag.
REQ-014 ovf_pred  out  1  predicted 8-bit overflow of the pending operation (see Configuration).

Function
REQ-015 FSM states SHALL be LOAD, ISSUE, WAIT_DONE and WAIT_CLR, plus a 2-bit byte counter cnt and a 4-bit watchdog counter wd.
REQ-016 In LOAD: in_ready=1; an accept (in_valid & in_ready) SHALL write in_data to A, B, C, D for cnt = 0, 1, 2, 3 respectively, then increment cnt.
REQ-017 mode SHALL be registered from in_mode only on the accept with cnt=0.
REQ-018 The accept at cnt=3 SHALL wrap cnt to 0 and move to ISSUE on the next edge.
REQ-019 In ISSUE: start=1, wd cleared; next state WAIT_DONE unconditionally.
REQ-020 In WAIT_DONE: start=1; wd increments each cycle. done=1 SHALL move to WAIT_CLR. wd=15 with done=0 SHALL set err and move to LOAD.
REQ-021 In WAIT_CLR: start=0; remain until done=0, then move to LOAD.
REQ-022 in_ready SHALL be 0 outside LOAD; in_valid there SHALL be ignored and no state SHALL change.
REQ-023 A-D and mode SHALL change only on LOAD accepts and SHALL hold stable from ISSUE through WAIT_CLR.
REQ-024 err SHALL clear only on reset.
REQ-025 start, in_ready and busy SHALL be decoded from registered state only, with no combinational path from in_valid or done.
REQ-026 The first byte SHALL be accepted one cycle after reset deasserts; start SHALL rise on the edge after the fourth accept.

Reset
REQ-027 On reset, state SHALL be LOAD, cnt=0, wd=0, A=B=C=D=0, mode=0, start=0, err=0 and ovf_pred=0.
REQ-028 Reset asserted mid-load or mid-operation SHALL discard partial operands and override every other transition in that cycle.

Configuration
REQ-029 With macro OPLOAD_OVF_PREDICT_EN defined, on entry to ISSUE the block SHALL register a 10-bit signed result: mode 0 = A+B+C-D, mode 1 = A-B+C+D.
REQ-030 With OPLOAD_OVF_PREDICT_EN defined, ovf_pred SHALL be 1 when that result lies outside -128..127, held until the next ISSUE.
REQ-031 Without OPLOAD_OVF_PREDICT_EN, the ovf_pred port SHALL remain and be tied to 0, and no predictor logic SHALL be built.

Verification
REQ-032 Bytes 01,02,FF,02 with mode 0 on the first byte -> A=1, B=-1 at C, D=2 (A=1, B=2, C=-1, D=2), start high one cycle after the fourth accept; done pulse -> start=0 next cycle; ovf_pred=0.
REQ-033 Bytes FE,01,01,04 with mode 1 -> A=-2, D=4, mode=1; predicted result 2; ovf_pred=0.
REQ-034 Bytes 7F,7F,00,00 with mode 0 -> predicted result 254, ovf_pred=1 (0 when macro undefined).
REQ-035 done held 0 after ISSUE -> err=1 and state LOAD after 16 cycles in WAIT_DONE; err persists until reset.
REQ-036 Reset after two accepts -> A=B=0, cnt=0; the next four bytes load A-D from A.
REQ-037 in_valid=1 with byte 55 during WAIT_DONE -> in_ready=0 and A-D unchanged.
